cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares one external memory port between the instruction-cache and data-cache miss paths.
//  Arbitrates requests and sequences command, write and read-burst handshakes.
//  Routes refill beats back to the owning cache and raises a pipeline stall while any miss is outstanding.
//  Sits between the icache/dcache controllers and the memory controller; stall feeds the datapath Stall input.
// PARAMETERS
//  ADDR_W     32  address width (byte address, passed through unmodified)
//  DATA_W     32  memory data beat width
//  BURST_LEN  4   read-refill beats per read command (>=1; power of two not required)
// PORTS
//  CLK             in   1       single clock; all state updates on posedge
//  reset_n         in   1       asynchronous, active-low reset
//  ic_req_valid    in   1       icache read-miss request (read only)
//  ic_req_addr     in   ADDR_W  icache refill address
//  ic_req_ready    out  1       icache request accepted this cycle
//  ic_resp_valid   out  1       resp_data is an icache refill beat
//  dc_req_valid    in   1       dcache request
//  dc_req_we       in   1       1 = single-beat write, 0 = burst read
//  dc_req_addr     in   ADDR_W  dcache address
//  dc_req_wdata    in   DATA_W  write data (dc_req_we=1)
//  dc_req_ready    out  1       dcache request accepted this cycle
//  dc_resp_valid   out  1       resp_data is a dcache beat, or a write ack
//  resp_data       out  DATA_W  shared response data; 0 on write ack
//  resp_last       out  1       final beat or write ack of the current transaction
//  mem_cmd_valid   out  1       command valid to memory
//  mem_cmd_ready   in   1       memory accepts command
//  mem_cmd_we      out  1       command is a write
//  mem_cmd_addr    out  ADDR_W  command address
//  mem_cmd_wdata   out  DATA_W  write data, valid with mem_cmd_valid when mem_cmd_we=1
//  mem_rdata_valid in   1       read beat from memory
//  mem_rdata       in   DATA_W  read beat data
//  stall           out  1       hold the pipeline
//  protocol_err    out  1       sticky: unexpected mem_rdata_valid
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, beat_cnt=0, last_grant=IC.
//   - All outputs 0 except stall, which is combinational and still follows the request inputs.
//   - An in-flight transaction is abandoned; no response is issued.
//  FSM: IDLE -> CMD -> (RDATA | IDLE).
//  IDLE:
//   - Grant to at most one requester; the grant is visible as a 1-cycle req_ready pulse.
//   - Single requester valid: grant it.
//   - Both valid: grant the one not in last_grant (round robin). After reset, the first tie goes to DC.
//   - On grant: latch owner, we, addr, wdata; update last_grant; go to CMD next cycle.
//   - Requesters hold req_valid/addr stable until ready, then drop valid.
//  CMD:
//   - mem_cmd_valid=1 with registered we/addr/wdata; held until mem_cmd_ready (no timeout).
//   - Write, on handshake: next cycle dc_resp_valid=1, resp_last=1, resp_data=0 for 1 cycle; state -> IDLE.
//   - Read, on handshake: state -> RDATA, beat_cnt=0.
//  RDATA:
//   - Each mem_rdata_valid is registered and appears 1 cycle later on resp_data with the owner's resp_valid.
//   - beat_cnt increments on each beat.
//   - resp_last=1 on beat BURST_LEN-1; the state returns to IDLE in the same edge that registers that beat.
//   - Beats need not be contiguous; idle cycles between beats are allowed.
//  New grant timing: a new grant may occur in the cycle IDLE is re-entered. Earliest back-to-back request
//   acceptance is 1 cycle after the write ack / last beat is registered.
//  stall = (state != IDLE) | ic_req_valid | dc_req_valid | any resp_valid pending.
//   - stall deasserts the cycle after the final response when no request is waiting.
//  protocol_err: sets on mem_rdata_valid in IDLE or CMD, including beats arriving after reset; cleared only
//   by reset. Such beats are dropped, never forwarded.
//  Never: ic and dc resp_valid both high; two ready pulses in one cycle; ic write.
//  beat_cnt width = $clog2(BURST_LEN+1); no wrap inside a burst.
// TESTING
//  - IC read 0x400: ic_req_valid, cmd_ready same cycle, 4 beats A0..A3 -> ic_resp_valid x4, resp_last on A3, stall low the cycle after.
//  - IC and DC valid together after reset -> dc_req_ready first; next tie -> ic granted; third tie -> dc.
//  - DC write addr 0x10 data 0xDEADBEEF, mem_cmd_ready delayed 3 cycles -> cmd held stable 4 cycles, then 1-cycle dc_resp_valid/resp_last, resp_data=0.
//  - Read burst with gaps (beats on cycles 0, 3, 4, 9) -> 4 responses, each 1 cycle after its beat, resp_last only on 4th, stall high throughout.
//  - reset_n low after 2 of 4 beats, then beats 3-4 arrive -> no responses, protocol_err=1, state IDLE, next request served normally.
//  - mem_rdata_valid in IDLE with no request -> protocol_err sets and stays set; no resp_valid.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one memory command/read port between icache refills and dcache reads/writes.
// Round-robin grant, command handshake, burst refill routing, pipeline stall and sticky protocol error.
module cache_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_cmd_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              protocol_err
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_RDATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              ic_req_ready_q, ic_req_ready_d;
  logic              dc_req_ready_q, dc_req_ready_d;
  logic              ic_resp_valid_q, ic_resp_valid_d;
  logic              dc_resp_valid_q, dc_resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_last_q, resp_last_d;
  logic              protocol_err_q, protocol_err_d;
  logic              grant_dc;

  // State register and registered outputs
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IC;
      last_grant_q    <= OWN_IC;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      beat_cnt_q      <= '0;
      ic_req_ready_q  <= 1'b0;
      dc_req_ready_q  <= 1'b0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      resp_data_q     <= '0;
      resp_last_q     <= 1'b0;
      protocol_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      beat_cnt_q      <= beat_cnt_d;
      ic_req_ready_q  <= ic_req_ready_d;
      dc_req_ready_q  <= dc_req_ready_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      dc_resp_valid_q <= dc_resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_last_q     <= resp_last_d;
      protocol_err_q  <= protocol_err_d;
    end
  end

  // Next-state, grant and response sequencing
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    beat_cnt_d      = beat_cnt_q;
    ic_req_ready_d  = 1'b0;
    dc_req_ready_d  = 1'b0;
    ic_resp_valid_d = 1'b0;
    dc_resp_valid_d = 1'b0;
    resp_data_d     = '0;
    resp_last_d     = 1'b0;
    grant_dc        = 1'b0;
    // Beats outside a refill are dropped and flagged
    protocol_err_d  = protocol_err_q | (mem_rdata_valid && (state_q != ST_RDATA));

    case (state_q)
      ST_IDLE: begin
        grant_dc = dc_req_valid && (!ic_req_valid || (last_grant_q == OWN_IC));
        if (grant_dc) begin
          dc_req_ready_d = 1'b1;
          owner_d        = OWN_DC;
          last_grant_d   = OWN_DC;
          we_d           = dc_req_we;
          addr_d         = dc_req_addr;
          wdata_d        = dc_req_wdata;
          state_d        = ST_CMD;
        end else if (ic_req_valid) begin
          ic_req_ready_d = 1'b1;
          owner_d        = OWN_IC;
          last_grant_d   = OWN_IC;
          we_d           = 1'b0;
          addr_d         = ic_req_addr;
          wdata_d        = '0;
          state_d        = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (mem_cmd_ready) begin
          if (we_q) begin
            dc_resp_valid_d = 1'b1;
            resp_last_d     = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            beat_cnt_d = '0;
            state_d    = ST_RDATA;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_RDATA: begin
        if (mem_rdata_valid) begin
          resp_data_d = mem_rdata;
          if (owner_q == OWN_DC) begin
            dc_resp_valid_d = 1'b1;
          end else begin
            ic_resp_valid_d = 1'b1;
          end
          if (beat_cnt_q == LAST_BEAT) begin
            resp_last_d = 1'b1;
            beat_cnt_d  = '0;
            state_d     = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_RDATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ic_req_ready  = ic_req_ready_q;
  assign dc_req_ready  = dc_req_ready_q;
  assign ic_resp_valid = ic_resp_valid_q;
  assign dc_resp_valid = dc_resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_last     = resp_last_q;
  assign mem_cmd_valid = (state_q == ST_CMD);
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_wdata = wdata_q;
  assign protocol_err  = protocol_err_q;
  // Stall is combinational so a fresh miss holds the pipeline in its own cycle, even in reset
  assign stall = (state_q != ST_IDLE) | ic_req_valid | dc_req_valid | ic_resp_valid_q | dc_resp_valid_q;

endmodule
